simd_dot_stream: RTL and testbench

//   Streaming front end for the SIMD dot-product datapath. Accepts a vector of

---
 rtl/simd_dot_stream.sv | 181 ++++++++++++++++++
 tb/tb_simd_dot_stream.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_dot_stream.sv
// -----------------------------------------------------------------------------
// simd_dot_stream
//
// Streaming front end for the SIMD dot-product datapath. Each accepted pair of
// packed 32-bit operand words is reduced to an unsigned lane-wise dot product
// (lane width selected by the mode), registered into a one-stage pipe, and
// summed into a wrapping accumulator. Once the programmed number of words has
// been accepted and the pipe has drained, the accumulated value is offered on
// a valid/ready result port.
//
// Parameters
//   ACC_W  accumulator / out_data width (must be >= 34)
//   LEN_W  width of cfg_len (vector length in words)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   cfg_mode   lane mode: 0=int2 (16 lanes), 1=int4 (8), 2=int8 (4), 3=int16 (2)
//   cfg_len    vector length in word pairs, latched on start
//   start      one-cycle pulse, honoured only in IDLE
//   busy       high whenever the block is not IDLE
//   in_valid   operand word pair valid
//   in_ready   operand word pair accepted when high together with in_valid
//   in_a       packed operand A
//   in_b       packed operand B
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_data   accumulated dot product, modulo 2^ACC_W
//   out_ovf    sticky: accumulator carried out of ACC_W during this operation
// -----------------------------------------------------------------------------
module simd_dot_stream #(
    parameter int ACC_W = 48,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  count_next;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              p1_valid;
    logic [32:0]       p1_dp;
    logic [32:0]       word_dp;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W:0]    acc_sum;
    logic              ovf_q;

    // Unsigned lane-wise dot product of one word pair. 33 bits covers the
    // worst case, two int16 lanes of (2^16-1)^2 each.
    function automatic logic [32:0] dot_word(input logic [1:0]  mode,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [32:0] sum;
        // NOTE: give every combinationally computed variable a value before any
        // branch; a path that leaves it unassigned would infer a latch.
        sum = '0;
        case (mode)
            2'd0: for (int i = 0; i < 16; i++)
                      sum += 33'(a[2*i +: 2]) * 33'(b[2*i +: 2]);
            2'd1: for (int i = 0; i < 8; i++)
                      sum += 33'(a[4*i +: 4]) * 33'(b[4*i +: 4]);
            2'd2: for (int i = 0; i < 4; i++)
                      sum += 33'(a[8*i +: 8]) * 33'(b[8*i +: 8]);
            default: for (int i = 0; i < 2; i++)
                      sum += 33'(a[16*i +: 16]) * 33'(b[16*i +: 16]);
        endcase
        return sum;
    endfunction

    assign word_dp    = dot_word(mode_q, in_a, in_b);
    assign count_next = count + LEN_W'(1);
    // One extra bit captures the carry out of the accumulator for out_ovf.
    assign acc_sum    = {1'b0, acc} + (ACC_W+1)'(p1_dp);

    always_ff @(posedge clk) begin
        // NOTE: all state here is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state       <= S_IDLE;
            mode_q      <= '0;
            len_q       <= '0;
            count       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            p1_valid    <= 1'b0;
            p1_dp       <= '0;
            acc         <= '0;
            ovf_q       <= 1'b0;
        end else begin
            p1_valid <= 1'b0;

            // The pipe stage is folded into the accumulator whenever it holds
            // a word, independent of the control state (covers RUN and DRAIN).
            if (p1_valid) begin
                acc <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W])
                    ovf_q <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= cfg_mode;
                        len_q  <= cfg_len;
                        acc    <= '0;
                        count  <= '0;
                        ovf_q  <= 1'b0;
                        if (cfg_len == '0) begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state      <= S_RUN;
                            in_ready_q <= 1'b1;
                        end
                    end
                end

                // in_ready stays registered: it is high for the whole of RUN
                // (count < len there) and drops on the edge taking the last word.
                S_RUN: begin
                    if (in_valid && in_ready_q) begin
                        p1_dp    <= word_dp;
                        p1_valid <= 1'b1;
                        count    <= count_next;
                        if (count_next == len_q) begin
                            in_ready_q <= 1'b0;
                            state      <= S_DRAIN;
                        end
                    end
                end

                // The last word sits in P1 during this cycle and is added on
                // the edge that leaves DRAIN.
                S_DRAIN: begin
                    state       <= S_DONE;
                    out_valid_q <= 1'b1;
                end

                S_DONE: begin
                    if (out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_simd_dot_stream.sv
// -----------------------------------------------------------------------------
// tb_simd_dot_stream
//
// Drives two instances of simd_dot_stream (ACC_W=48 and ACC_W=34) with the
// same stimulus. Expected results come from a lane-by-lane arithmetic model:
// the exact vector sum is kept at 64 bits, the result is that sum modulo
// 2^ACC_W and the overflow flag is set when the exact sum reaches 2^ACC_W.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_simd_dot_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_len;
    logic        start;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_ready;

    logic        busy, in_ready, out_valid, out_ovf;
    logic [47:0] out_data;
    logic        busy_n, in_ready_n, out_valid_n, out_ovf_n;
    logic [33:0] out_data_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    simd_dot_stream #(.ACC_W(48), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .start(start), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    simd_dot_stream #(.ACC_W(34), .LEN_W(16)) dut_n (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .start(start), .busy(busy_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_data(out_data_n), .out_ovf(out_ovf_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: split each word into 32/W unsigned lanes and sum the products.
    function automatic longint unsigned ref_dp(input int mode, input logic [31:0] a,
                                               input logic [31:0] b);
        int w = 2 << mode;
        int lanes = 32 / w;
        longint unsigned m = (64'd1 << w) - 64'd1;
        longint unsigned s = 0;
        for (int i = 0; i < lanes; i++)
            s += ((64'(a) >> (i * w)) & m) * ((64'(b) >> (i * w)) & m);
        return s;
    endfunction

    task automatic check_results(input string tag, input longint unsigned sum);
        logic [63:0] m48 = (64'd1 << 48) - 64'd1;
        logic [63:0] m34 = (64'd1 << 34) - 64'd1;
        check({tag, "_data48"}, 64'(out_data), sum & m48);
        check({tag, "_ovf48"}, 64'(out_ovf), 64'((sum >> 48) != 0));
        check({tag, "_data34"}, 64'(out_data_n), sum & m34);
        check({tag, "_ovf34"}, 64'(out_ovf_n), 64'((sum >> 34) != 0));
    endtask

    // One complete operation using the operands queued in qa/qb.
    // gap < 0 picks a random 0..2 idle cycles before each word.
    task automatic run_op(input int mode, input int len, input int gap,
                          input int stall, input bit start_in_done);
        longint unsigned sum = 0;
        int g;
        int budget;
        for (int k = 0; k < len; k++)
            sum += ref_dp(mode, qa[k], qb[k]);

        @(negedge clk);
        cfg_mode = 2'(mode);
        cfg_len  = 16'(len);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        // Scrambling config after start must not affect the running operation.
        cfg_mode = 2'($urandom);
        cfg_len  = 16'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        if (len == 0) begin
            check("len0_valid", 64'(out_valid), 64'd1);
            check("len0_ready", 64'(in_ready), 64'd0);
        end else begin
            check("run_ready", 64'(in_ready), 64'd1);
        end

        for (int k = 0; k < len; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                in_valid = 1'b0;
                in_a     = $urandom;
                in_b     = $urandom;
                check("gap_ready", 64'(in_ready), 64'd1);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_a     = qa[k];
            in_b     = qb[k];
            budget   = 0;
            while (!in_ready && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (budget != 0)
                check("ready_wait", 64'(budget), 64'd0);
            @(negedge clk);
        end

        if (len > 0) begin
            in_valid = 1'b0;
            check("lat1_valid", 64'(out_valid), 64'd0);
            check("lat1_ready", 64'(in_ready), 64'd0);
            check("lat1_busy", 64'(busy), 64'd1);
            @(negedge clk);
            check("lat2_valid", 64'(out_valid), 64'd1);
        end
        check_results("done", sum);

        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (start_in_done) begin
                start   = 1'b1;
                cfg_len = 16'd3;
            end
            @(negedge clk);
            start = 1'b0;
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_ready", 64'(in_ready), 64'd0);
            check("stall_busy", 64'(busy), 64'd1);
            check_results("stall", sum);
        end

        out_ready = 1'b1;
        start     = start_in_done;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("hs_valid", 64'(out_valid), 64'd0);
        check("hs_busy", 64'(busy), 64'd0);
        check("hs_ready", 64'(in_ready), 64'd0);
        if (start_in_done) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
        end
        qa.delete();
        qb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        int len;
        rst       = 1'b1;
        cfg_mode  = '0;
        cfg_len   = '0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_ovf", 64'(out_ovf), 64'd0);
        rst = 1'b0;

        // int8, two back-to-back words of dot product 10 each.
        qa = '{32'h01020304, 32'h01020304};
        qb = '{32'h01010101, 32'h01010101};
        run_op(2, 2, 0, 0, 1'b0);
        check("t1_const", 64'(out_data), 64'd20);

        // All-ones operands in int2, int16, int4.
        qa = '{32'hFFFFFFFF}; qb = '{32'hFFFFFFFF};
        run_op(0, 1, 0, 1, 1'b0);
        check("t2_int2", 64'(out_data), 64'd144);
        qa = '{32'hFFFFFFFF}; qb = '{32'hFFFFFFFF};
        run_op(3, 1, 0, 0, 1'b0);
        check("t2_int16", 64'(out_data), 64'h1_FFFC_0002);
        qa = '{32'hFFFFFFFF}; qb = '{32'hFFFFFFFF};
        run_op(1, 1, 0, 0, 1'b0);
        check("t2_int4", 64'(out_data), 64'd1800);

        // Back-pressure: gaps on input, stalled output, start pulses in DONE.
        for (int k = 0; k < 3; k++) begin
            qa.push_back($urandom);
            qb.push_back($urandom);
        end
        run_op(1, 3, 2, 3, 1'b1);

        // Zero-length vector.
        run_op(2, 0, 0, 1, 1'b0);
        check("t4_data", 64'(out_data), 64'd0);
        check("t4_ovf", 64'(out_ovf), 64'd0);

        // Overflow of the 34-bit instance, then cleared by the next operation.
        qa = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        qb = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        run_op(3, 3, 0, 0, 1'b0);
        check("t5_data34", 64'(out_data_n), 64'h1_FFF4_0006);
        check("t5_ovf34", 64'(out_ovf_n), 64'd1);
        qa = '{32'h00010001}; qb = '{32'h00010001};
        run_op(3, 1, 0, 0, 1'b0);
        check("t5_clear", 64'(out_ovf_n), 64'd0);

        // Reset after one of three words, then a fresh operation.
        @(negedge clk);
        cfg_mode = 2'd2;
        cfg_len  = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = 32'h11223344;
        in_b     = 32'h55667788;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_ready", 64'(in_ready), 64'd0);
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_data", 64'(out_data), 64'd0);
        check("t6_ovf", 64'(out_ovf), 64'd0);
        check("t6_busy34", 64'(busy_n), 64'd0);
        qa = '{32'h02020202}; qb = '{32'h02020202};
        run_op(2, 1, 0, 0, 1'b0);
        check("t6_fresh", 64'(out_data), 64'd16);

        // Randomised operations.
        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 3));
            len  = int'($urandom_range(0, 7));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    qa.push_back(32'hFFFFFFFF);
                    qb.push_back(32'hFFFFFFFF);
                end else begin
                    qa.push_back($urandom);
                    qb.push_back($urandom);
                end
            end
            run_op(mode, len, -1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
